mem_arbiter: RTL and testbench

//  Two-port arbiter and sequencer for the single-port 1 KiB on-chip memory (1-cycle synchronous read).

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter/sequencer for a single-port synchronous memory with a
//   1-cycle read latency. Port 0 is the Z80 bus side and port 1 is the
//   loader/debug DMA side. Each transaction walks IDLE -> ISSUE -> CAPT -> ACK.
//   The arbiter only picks a winner in IDLE.
//
// Ports
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   pN_req/we/addr/wdata        request held stable by port N until pN_ack
//   pN_ack                      one-cycle completion pulse
//   pN_rdata                    last read data for port N
//   mem_addr/wdata/we           registered drive to the memory
//   mem_rdata                   memory read data, valid one cycle after ISSUE
//   busy                        high whenever the FSM is not in IDLE
//   gnt_id                      port of the current or most recent transaction
module mem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, ACK} state_t;

  state_t state;
  logic   last_gnt;  // port granted most recently; resets to 1 so port 0 wins the first tie
  logic   cur_we;    // operation type of the transaction in flight (mem_we drops after ISSUE)
  logic   win;       // winner among the currently asserted requests

  always_comb begin
    win = 1'b0;
    if (p0_req && p1_req) begin
      win = (PRIO_MODE != 0) ? 1'b0 : ~last_gnt;
    end else if (p1_req) begin
      win = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      cur_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      gnt_id    <= 1'b0;
      busy      <= 1'b0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            gnt_id    <= win;
            last_gnt  <= win;
            mem_addr  <= win ? p1_addr  : p0_addr;
            mem_wdata <= win ? p1_wdata : p0_wdata;
            mem_we    <= win ? p1_we    : p0_we;
            cur_we    <= win ? p1_we    : p0_we;
          end
        end
        ISSUE: begin
          // The memory commits the write / samples the read address on this edge.
          mem_we <= 1'b0;
          state  <= CAPT;
        end
        CAPT: begin
          // A write leaves rdata alone; the memory's old-data output is ignored.
          if (!cur_we) begin
            if (gnt_id) p1_rdata <= mem_rdata;
            else        p0_rdata <= mem_rdata;
          end
          p0_ack <= ~gnt_id;
          p1_ack <= gnt_id;
          state  <= ACK;
        end
        ACK: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter. Two instances are used: dut_rr runs in round-robin
//   mode and dut_fp runs in fixed-priority mode. Each instance has its own
//   behavioural memory. Expected grants and data come from a transaction-level
//   model that holds a reference memory and the last-granted port.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]    a_req, a_we, a_ack;
  logic [AW-1:0] a_addr [2];
  logic [DW-1:0] a_wdata [2];
  logic [DW-1:0] a_rdata [2];
  logic [AW-1:0] a_mem_addr;
  logic [DW-1:0] a_mem_wdata, a_mem_rdata;
  logic          a_mem_we, a_busy, a_gnt_id;

  logic [1:0]    b_req, b_we, b_ack;
  logic [AW-1:0] b_addr [2];
  logic [DW-1:0] b_wdata [2];
  logic [DW-1:0] b_rdata [2];
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_mem_rdata;
  logic          b_mem_we, b_busy, b_gnt_id;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .reset(reset),
    .p0_req(a_req[0]), .p0_we(a_we[0]), .p0_addr(a_addr[0]), .p0_wdata(a_wdata[0]),
    .p0_ack(a_ack[0]), .p0_rdata(a_rdata[0]),
    .p1_req(a_req[1]), .p1_we(a_we[1]), .p1_addr(a_addr[1]), .p1_wdata(a_wdata[1]),
    .p1_ack(a_ack[1]), .p1_rdata(a_rdata[1]),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .gnt_id(a_gnt_id)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_req(b_req[0]), .p0_we(b_we[0]), .p0_addr(b_addr[0]), .p0_wdata(b_wdata[0]),
    .p0_ack(b_ack[0]), .p0_rdata(b_rdata[0]),
    .p1_req(b_req[1]), .p1_we(b_we[1]), .p1_addr(b_addr[1]), .p1_wdata(b_wdata[1]),
    .p1_ack(b_ack[1]), .p1_rdata(b_rdata[1]),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .gnt_id(b_gnt_id)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i) ^ 8'h10;
  endfunction

  // Behavioural single-port memories: write commit and registered read on the same edge.
  logic [DW-1:0] mem_a [1<<AW];
  logic [DW-1:0] mem_b [1<<AW];
  logic          mem_init, pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  int            a_we_cycles = 0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1<<AW); i++) begin
        mem_a[i] <= init_val(i);
        mem_b[i] <= init_val(i);
      end
    end else begin
      if (pl_en)         mem_a[pl_addr]    <= pl_data;
      else if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
      if (b_mem_we)      mem_b[b_mem_addr] <= b_mem_wdata;
    end
    a_mem_rdata <= mem_a[a_mem_addr];
    b_mem_rdata <= mem_b[b_mem_addr];
    if (a_mem_we === 1'b1) a_we_cycles <= a_we_cycles + 1;
  end

  // Transaction-level reference model.
  logic [DW-1:0] ref_mem [1<<AW];
  logic          model_last;
  logic [DW-1:0] model_rdata [2];
  int            errors = 0;
  int            checks = 0;

  function automatic int pick(input logic r0, input logic r1, input logic prio);
    if (r0 && r1) return prio ? 0 : (model_last ? 0 : 1);
    return r0 ? 0 : 1;
  endfunction

  task automatic model_commit(input int port, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata);
    model_last = (port == 1);
    if (we) ref_mem[addr] = wdata;
    else    model_rdata[port] = ref_mem[addr];
  endtask

  task automatic model_reset();
    model_last     = 1'b1;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_req = '0;
    b_req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Advances until an ack shows on the chosen instance (bounded).
  // port: 0/1 for a single ack, 2 for an illegal pattern, -1 on timeout.
  task automatic wait_ack(input logic which, output int port, output int cyc);
    logic [1:0] ak;
    port = -1;
    cyc  = 0;
    while (cyc < 12 && port < 0) begin
      @(posedge clk);
      #1;
      cyc++;
      ak = which ? b_ack : a_ack;
      if (ak == 2'b01)      port = 0;
      else if (ak == 2'b10) port = 1;
      else if (ak != 2'b00) port = 2;
    end
  endtask

  // One round on dut_rr: present requests, then retire them in the order the model predicts.
  task automatic run_round(input logic [1:0] en, input logic [1:0] we,
                           input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1, input string tag);
    logic [1:0]    pend;
    logic [AW-1:0] ad [2];
    logic [DW-1:0] dd [2];
    int port, cyc, exp, n;
    ad[0] = ad0; ad[1] = ad1; dd[0] = d0; dd[1] = d1;
    a_we = we; a_addr[0] = ad0; a_addr[1] = ad1; a_wdata[0] = d0; a_wdata[1] = d1;
    a_req = en;
    pend  = en;
    n     = 0;
    while (pend != 2'b00) begin
      exp = pick(pend[0], pend[1], 1'b0);
      wait_ack(1'b0, port, cyc);
      checks++;
      if (port != exp) begin
        errors++;
        $display("FAIL %s grant: ack_port=%0d expected=%0d", tag, port, exp);
        a_req = '0;
        pend  = '0;
        repeat (4) @(posedge clk);
        #1;
      end else begin
        model_commit(exp, we[exp], ad[exp], dd[exp]);
        checks++;
        if (cyc != ((n == 0) ? 3 : 4)) begin
          errors++;
          $display("FAIL %s latency: cycles=%0d expected=%0d", tag, cyc, (n == 0) ? 3 : 4);
        end
        checks++;
        if (a_gnt_id !== 1'(exp)) begin
          errors++;
          $display("FAIL %s gnt_id: got=%0d expected=%0d", tag, a_gnt_id, exp);
        end
        for (int p = 0; p < 2; p++) begin
          checks++;
          if (a_rdata[p] !== model_rdata[p]) begin
            errors++;
            $display("FAIL %s p%0d_rdata: got=%h expected=%h", tag, p, a_rdata[p], model_rdata[p]);
          end
        end
        a_req[exp] = 1'b0;
        pend[exp]  = 1'b0;
        n++;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_idle: got=%b expected=0", tag, a_busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({a_ack, a_mem_we, a_busy, a_gnt_id} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl_rr: got=%b expected=00000", {a_ack, a_mem_we, a_busy, a_gnt_id});
    end
    checks++;
    if ({a_mem_addr, a_mem_wdata, a_rdata[0], a_rdata[1]} !== '0) begin
      errors++;
      $display("FAIL reset_data_rr: addr=%h wdata=%h rd0=%h rd1=%h expected all 0",
               a_mem_addr, a_mem_wdata, a_rdata[0], a_rdata[1]);
    end
    checks++;
    if ({b_ack, b_mem_we, b_busy, b_gnt_id} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl_fp: got=%b expected=00000", {b_ack, b_mem_we, b_busy, b_gnt_id});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single_read();
    pl_en = 1'b1; pl_addr = 10'h005; pl_data = 8'h3E;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
    ref_mem[10'h005] = 8'h3E;
    run_round(2'b01, 2'b00, 10'h005, '0, '0, '0, "t1_read");
    checks++;
    if (a_rdata[0] !== 8'h3E) begin
      errors++;
      $display("FAIL t1_rdata: got=%h expected=3e", a_rdata[0]);
    end
  endtask

  task automatic test_write_read_top();
    int we0;
    we0 = a_we_cycles;
    run_round(2'b10, 2'b10, '0, 10'h3FF, '0, 8'hA5, "t2_write");
    run_round(2'b10, 2'b00, '0, 10'h3FF, '0, '0, "t2_read");
    checks++;
    if (a_rdata[1] !== 8'hA5) begin
      errors++;
      $display("FAIL t2_rdata: got=%h expected=a5", a_rdata[1]);
    end
    checks++;
    if (a_we_cycles - we0 != 1) begin
      errors++;
      $display("FAIL t2_we_cycles: got=%0d expected=1", a_we_cycles - we0);
    end
  endtask

  task automatic test_rr_hold();
    int port, cyc, exp;
    do_reset();
    a_we = '0; a_addr[0] = 10'h031; a_addr[1] = 10'h2C4;
    a_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp = pick(1'b1, 1'b1, 1'b0);
      wait_ack(1'b0, port, cyc);
      checks++;
      if (port != exp) begin
        errors++;
        $display("FAIL t3_grant%0d: ack_port=%0d expected=%0d", k, port, exp);
      end
      checks++;
      if (cyc != ((k == 0) ? 3 : 4)) begin
        errors++;
        $display("FAIL t3_spacing%0d: cycles=%0d expected=%0d", k, cyc, (k == 0) ? 3 : 4);
      end
      model_commit(exp, 1'b0, a_addr[exp], '0);
      checks++;
      if (a_rdata[exp] !== model_rdata[exp]) begin
        errors++;
        $display("FAIL t3_rdata%0d: got=%h expected=%h", k, a_rdata[exp], model_rdata[exp]);
      end
      if (k == 3) a_req = '0;
    end
    @(posedge clk);
    #1;
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL t3_busy_idle: got=%b expected=0", a_busy);
    end
  endtask

  task automatic test_reset_mid_write();
    int acks;
    a_we = 2'b01; a_addr[0] = 10'h010; a_wdata[0] = 8'h55;
    a_req = 2'b01;
    @(posedge clk);
    #1;
    checks++;
    if (a_mem_we !== 1'b1) begin
      errors++;
      $display("FAIL t5_we_issue: got=%b expected=1", a_mem_we);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({a_mem_we, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL t5_async_drop: we_busy=%b expected=00", {a_mem_we, a_busy});
    end
    checks++;
    if ({a_rdata[0], a_rdata[1]} !== '0) begin
      errors++;
      $display("FAIL t5_rdata_clr: rd0=%h rd1=%h expected 0", a_rdata[0], a_rdata[1]);
    end
    a_req = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    acks = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (a_ack != 2'b00) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL t5_no_ack: ack_cycles=%0d expected=0", acks);
    end
    run_round(2'b01, 2'b00, 10'h010, '0, '0, '0, "t5_read");
    checks++;
    if (a_rdata[0] !== 8'h00) begin
      errors++;
      $display("FAIL t5_mem_intact: got=%h expected=00", a_rdata[0]);
    end
  endtask

  task automatic test_read_vs_write();
    run_round(2'b01, 2'b00, 10'h020, '0, '0, '0, "t6_prime");
    run_round(2'b11, 2'b10, 10'h123, 10'h123, '0, 8'hC7, "t6_race");
    checks++;
    if (a_rdata[0] !== 8'hC7) begin
      errors++;
      $display("FAIL t6_rdata: got=%h expected=c7", a_rdata[0]);
    end
  endtask

  task automatic test_fixed_prio();
    int port, cyc, exp;
    b_we = '0; b_addr[0] = 10'h0A1; b_addr[1] = 10'h0B2;
    b_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp = pick(b_req[0], b_req[1], 1'b1);
      wait_ack(1'b1, port, cyc);
      checks++;
      if (port != exp) begin
        errors++;
        $display("FAIL t4_grant%0d: ack_port=%0d expected=%0d", k, port, exp);
      end
      checks++;
      if (cyc != ((k == 0) ? 3 : 4)) begin
        errors++;
        $display("FAIL t4_spacing%0d: cycles=%0d expected=%0d", k, cyc, (k == 0) ? 3 : 4);
      end
      checks++;
      if (b_gnt_id !== 1'(exp) || b_rdata[exp] !== init_val(int'(b_addr[exp]))) begin
        errors++;
        $display("FAIL t4_data%0d: gnt=%0d rdata=%h expected gnt=%0d rdata=%h",
                 k, b_gnt_id, b_rdata[exp], exp, init_val(int'(b_addr[exp])));
      end
      if (k == 2) b_req[0] = 1'b0;
      if (k == 3) b_req[1] = 1'b0;
    end
    @(posedge clk);
    #1;
    checks++;
    if (b_busy !== 1'b0) begin
      errors++;
      $display("FAIL t4_busy_idle: got=%b expected=0", b_busy);
    end
  endtask

  task automatic test_random();
    logic [1:0]    en, we;
    logic [AW-1:0] ad0, ad1;
    for (int r = 0; r < 40; r++) begin
      en  = 2'($urandom_range(1, 3));
      we  = 2'($urandom_range(0, 3));
      ad0 = ($urandom_range(0, 4) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
      ad1 = ($urandom_range(0, 2) == 0) ? ad0 : AW'($urandom_range(0, 15));
      run_round(en, we, ad0, ad1, DW'($urandom), DW'($urandom), "rand");
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_init = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    a_req = '0; a_we = '0; b_req = '0; b_we = '0;
    for (int p = 0; p < 2; p++) begin
      a_addr[p] = '0; a_wdata[p] = '0; b_addr[p] = '0; b_wdata[p] = '0;
    end
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_val(i);
    model_reset();
    @(posedge clk);
    #1;
    mem_init = 1'b0;

    test_reset();
    test_single_read();
    test_write_read_top();
    test_rr_hold();
    test_reset_mid_write();
    test_read_vs_write();
    test_fixed_prio();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
